rega_sequenciador: RTL

//  Sequencer for the irrigation valve's 2-bit up/down level counter (levels 0..3).

---
 rtl/rega_sequenciador.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rega_sequenciador.sv
// Irrigation valve sequencer: paces a 2-bit up/down level counter
// through ramp-up, hold, ramp-down and lockout from soil/rain/tank sensors.
//
// Ports:
//   Clk          rising-edge clock
//   Rst          synchronous reset, active-low
//   Seco         soil dry (irrigation request)
//   Chuva        rain detected, inhibits irrigation
//   Tanque_baixo tank low, inhibits irrigation and raises the alarm
//   Cnt_Q[1:0]   level counter feedback
//   Cnt_Y        counter direction (1=up, 0=down)
//   Cnt_En       one-cycle step pulse to the counter
//   Valvula      valve open
//   Alarme       alarm (tank low or FAULT), registered
//   Estado[2:0]  IDLE=0 UP=1 HOLD=2 DOWN=3 LOCK=4 FAULT=5
//
// Optional feature macro: FEEDBACK_CHECK_EN
//   defined   -> Cnt_Q is checked against the expected level in the
//                cycle after every step; a mismatch locks into FAULT.
//   undefined -> no check, FAULT unreachable; Cnt_Q only resyncs
//                the expected level right after reset.

module rega_sequenciador #(
    parameter int STEP_CYCLES = 1000,
    parameter int HOLD_CYCLES = 5000,
    parameter int LOCK_CYCLES = 2000,
    parameter int MAX_LEVEL   = 3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Seco,
    input  logic       Chuva,
    input  logic       Tanque_baixo,
    input  logic [1:0] Cnt_Q,
    output logic       Cnt_Y,
    output logic       Cnt_En,
    output logic       Valvula,
    output logic       Alarme,
    output logic [2:0] Estado
);

    // Timer is sized for the longest of the three intervals.
    localparam int TMAX_SH = (STEP_CYCLES > HOLD_CYCLES)
                           ? STEP_CYCLES : HOLD_CYCLES;
    localparam int TMAX    = (TMAX_SH > LOCK_CYCLES)
                           ? TMAX_SH : LOCK_CYCLES;
    localparam int TW      = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
    localparam logic [1:0]    LVL_MAX   = 2'(MAX_LEVEL);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        HOLD  = 3'd2,
        DOWN  = 3'd3,
        LOCK  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [1:0]    exp_lvl;
    logic          sync_pend;
    logic          inhibit;
    logic          mismatch;

    assign inhibit = Chuva | Tanque_baixo;
    assign Estado  = state;

`ifdef FEEDBACK_CHECK_EN
    // chk marks the cycle right after a step pulse, when the counter
    // has already taken the step and Cnt_Q must equal exp_lvl.
    logic chk;

    assign mismatch = chk & (Cnt_Q != exp_lvl);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            chk <= 1'b0;
        end else begin
            chk <= Cnt_En;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= IDLE;
            timer     <= '0;
            exp_lvl   <= 2'd0;
            sync_pend <= 1'b1;
            Cnt_Y     <= 1'b0;
            Cnt_En    <= 1'b0;
            Valvula   <= 1'b0;
            Alarme    <= 1'b0;
        end else begin
            sync_pend <= 1'b0;
            Cnt_En    <= 1'b0;
            timer     <= timer + TW'(1);
            Alarme    <= Tanque_baixo
                       | mismatch
                       | (state == FAULT);

            if (mismatch) begin
                state   <= FAULT;
                timer   <= '0;
                Valvula <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        timer   <= '0;
                        Valvula <= 1'b0;
                        if (sync_pend) begin
                            exp_lvl <= Cnt_Q;
                        end
                        // A counter left above zero is drained
                        // before anything else is allowed.
                        if (sync_pend && (Cnt_Q != 2'd0)) begin
                            state   <= DOWN;
                            Cnt_Y   <= 1'b0;
                            Valvula <= 1'b1;
                        end else if (Seco && !inhibit) begin
                            state   <= UP;
                            Cnt_Y   <= 1'b1;
                            Valvula <= 1'b1;
                        end
                    end

                    UP: begin
                        Valvula <= 1'b1;
                        if (inhibit || !Seco) begin
                            state   <= DOWN;
                            timer   <= '0;
                            Cnt_Y   <= 1'b0;
                            Valvula <= (exp_lvl != 2'd0);
                        end else if (exp_lvl >= LVL_MAX) begin
                            // Reached the top on the previous
                            // pulse; leave once it has retired.
                            state <= HOLD;
                            timer <= '0;
                        end else if (timer == STEP_LAST) begin
                            Cnt_En  <= 1'b1;
                            exp_lvl <= exp_lvl + 2'd1;
                            timer   <= '0;
                        end
                    end

                    HOLD: begin
                        Valvula <= 1'b1;
                        if (inhibit) begin
                            state   <= DOWN;
                            timer   <= '0;
                            Cnt_Y   <= 1'b0;
                            Valvula <= (exp_lvl != 2'd0);
                        end else if (timer == HOLD_LAST) begin
                            timer <= '0;
                            if (!Seco) begin
                                state   <= DOWN;
                                Cnt_Y   <= 1'b0;
                                Valvula <= (exp_lvl != 2'd0);
                            end
                        end
                    end

                    DOWN: begin
                        if (exp_lvl == 2'd0) begin
                            state   <= LOCK;
                            timer   <= '0;
                            Valvula <= 1'b0;
                        end else if (timer == STEP_LAST) begin
                            Cnt_En  <= 1'b1;
                            exp_lvl <= exp_lvl - 2'd1;
                            timer   <= '0;
                            Valvula <= (exp_lvl != 2'd1);
                        end
                    end

                    LOCK: begin
                        Valvula <= 1'b0;
                        if (timer == LOCK_LAST) begin
                            state <= IDLE;
                            timer <= '0;
                        end
                    end

                    FAULT: begin
                        timer   <= '0;
                        Valvula <= 1'b0;
                    end

                    default: begin
                        state   <= IDLE;
                        timer   <= '0;
                        Valvula <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
